leading_zero_scan: RTL

LEADING_ZERO_SCAN -- requirements
Module: leading_zero_scan

---
 rtl/leading_zero_scan_pkg.sv | 15 +
 rtl/lz_chunk_enc.sv | 25 ++
 rtl/leading_zero_scan.sv | 130 +++++++++++++
 3 files changed

// File: rtl/leading_zero_scan_pkg.sv
// Shared types and constants for the chunked leading-zero scanner.
package leading_zero_scan_pkg;

    localparam int unsigned SW_DEF = 26;
    localparam int unsigned CW_DEF = 4;
    localparam int unsigned CNTW   = $clog2(SW_DEF + 1);
    localparam int unsigned NCHUNK = (SW_DEF + CW_DEF - 1) / CW_DEF;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } state_e;

endpackage

// File: rtl/lz_chunk_enc.sv
// Combinational leading-zero encoder for one MSB-aligned chunk.
module lz_chunk_enc #(
    parameter int unsigned CW    = 4,
    parameter int unsigned LASTW = 4,
    parameter int unsigned CCW   = $clog2(CW + 1)
) (
    input  logic [CW-1:0]  data,
    input  logic           last,
    output logic [CCW-1:0] count,
    output logic           nonzero
);

    always_comb begin
        // A narrower final chunk is MSB-aligned with zero padding below it, so a
        // nonzero count is unaffected; only the all-zero count needs its true width.
        count = last ? CCW'(LASTW) : CCW'(CW);
        for (int i = 0; i < CW; i++) begin
            if (data[i]) begin
                count = CCW'(CW - 1 - i);
            end
        end
        nonzero = |data;
    end

endmodule

// File: rtl/leading_zero_scan.sv
// Multi-cycle leading-zero scanner for the adder result, one chunk per cycle from the MSB.
module leading_zero_scan
    import leading_zero_scan_pkg::*;
#(
    parameter int unsigned SW = SW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_i,
    input  logic                       ack_i,
    input  logic [SW-1:0]              Data_i,
    input  logic                       Carry_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(SW+1)-1:0]    lz_count_o,
    output logic                       zero_o,
    output logic                       shift_right_o
);

    localparam int unsigned LCNTW = $clog2(SW + 1);
    localparam int unsigned NCH   = (SW + CW - 1) / CW;
    localparam int unsigned IW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PW    = NCH * CW;
    localparam int unsigned LASTW = SW - (NCH - 1) * CW;
    localparam int unsigned CCW   = $clog2(CW + 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [SW-1:0]     data_q, data_d;
    logic              carry_q, carry_d;
    logic [LCNTW-1:0]  lz_q, lz_d;
    logic              zero_q, zero_d;
    logic              sr_q, sr_d;

    logic [PW-1:0]     shifted;
    logic [CW-1:0]     chunk;
    logic              last_chunk;
    logic [CCW-1:0]    enc_count;
    logic              enc_nonzero;

    // Left-align the captured word in a whole number of chunks, then bring chunk idx to the top.
    always_comb begin
        shifted    = (PW'(data_q) << (PW - SW)) << (idx_q * CW);
        chunk      = shifted[PW-1 -: CW];
        last_chunk = (idx_q == IW'(NCH - 1));
    end

    lz_chunk_enc #(
        .CW    (CW),
        .LASTW (LASTW),
        .CCW   (CCW)
    ) u_enc (
        .data    (chunk),
        .last    (last_chunk),
        .count   (enc_count),
        .nonzero (enc_nonzero)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        carry_d = carry_q;
        lz_d    = lz_q;
        zero_d  = zero_q;
        sr_d    = sr_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    data_d  = Data_i;
                    carry_d = Carry_i;
                    lz_d    = '0;
                    zero_d  = 1'b0;
                    sr_d    = Carry_i;
                    idx_d   = '0;
                    state_d = Carry_i ? StDone : StScan;
                end
            end
            StScan: begin
                lz_d = lz_q + LCNTW'(enc_count);
                if (enc_nonzero) begin
                    state_d = StDone;
                end else if (last_chunk) begin
                    zero_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                if (ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            data_q  <= '0;
            carry_q <= 1'b0;
            lz_q    <= '0;
            zero_q  <= 1'b0;
            sr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            carry_q <= carry_d;
            lz_q    <= lz_d;
            zero_q  <= zero_d;
            sr_q    <= sr_d;
        end
    end

    // Captured carry only steers the FSM; the result reports it through shift_right_o.
    logic unused_carry;
    assign unused_carry = carry_q;

    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign lz_count_o    = lz_q;
    assign zero_o        = zero_q;
    assign shift_right_o = sr_q;

endmodule
